reg_file: RTL and testbench

Architectural integer register file for the single-cycle/pipelined RV32I core. It is the consumer of the write-back data word `rf_wd` and the producer of the operands `rd0` and `rd1` for the ALU and branch unit. It holds 32 × 32-bit registers, with x0 hardwired to zero, and provides:
- two operand read ports and one debug read port;
- a one-bit-per-register load scoreboard that raises `hazard` while an operand waits on an in-flight memory load.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/reg_scoreboard.sv | 57 +++++
 rtl/reg_file.sv | 67 ++++++
 tb/tb_reg_file.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: register addressing and write-back select encodings.
// Imported by reg_file and reg_scoreboard.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  // The decoder drives ld_issue for instructions selecting MEM_OUT.
  typedef enum logic [2:0] {
    NEXT_PC  = 3'd0,
    MEM_OUT  = 3'd1,
    ALU_OUT  = 3'd2,
    IMM_PC   = 3'd3,
    IMM_ONLY = 3'd4
  } wb_sel_e;

  function automatic logic is_load_wb(input wb_sel_e sel);
    return sel == MEM_OUT;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Load scoreboard: one busy bit per register, set on load issue, cleared on write-back.
// With RF_BYPASS_EN defined, a register being written this cycle does not raise hazard.
module reg_scoreboard
  import rv32_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(REG_NUM)-1:0] wa,
  input  logic                       ld_issue,
  input  logic [$clog2(REG_NUM)-1:0] ld_rd,
  input  logic                       flush,
  input  logic [$clog2(REG_NUM)-1:0] ra0,
  input  logic [$clog2(REG_NUM)-1:0] ra1,
  output logic                       hazard
);

  localparam int AW = $clog2(REG_NUM);

  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               wr_act;
  logic               haz0, haz1;

  assign wr_act = we && (wa != '0);

  // Clear before set so a younger load to the register being written wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_act)
        busy_d[wa] = 1'b0;
      if (ld_issue && (ld_rd != '0))
        busy_d[ld_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    haz0 = busy_q[ra0] && (ra0 != '0);
    haz1 = busy_q[ra1] && (ra1 != '0);
`ifdef RF_BYPASS_EN
    if (wr_act && (wa == ra0)) haz0 = 1'b0;
    if (wr_act && (wa == ra1)) haz1 = 1'b0;
`endif
    hazard = haz0 || haz1;
  end

endmodule

// File: rtl/reg_file.sv
// RV32I architectural register file: x0 hardwired to zero, two operand ports, one debug port.
// RF_BYPASS_EN forwards the same-cycle write-back word to rd0/rd1 and masks its hazard.
module reg_file
  import rv32_pkg::*;
#(
  parameter int XLEN    = rv32_pkg::XLEN,
  parameter int REG_NUM = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(REG_NUM)-1:0] ra0,
  input  logic [$clog2(REG_NUM)-1:0] ra1,
  output logic [XLEN-1:0]            rd0,
  output logic [XLEN-1:0]            rd1,
  input  logic                       we,
  input  logic [$clog2(REG_NUM)-1:0] wa,
  input  logic [XLEN-1:0]            wd,
  input  logic                       ld_issue,
  input  logic [$clog2(REG_NUM)-1:0] ld_rd,
  input  logic                       flush,
  output logic                       hazard,
  input  logic [$clog2(REG_NUM)-1:0] dbg_ra,
  output logic [XLEN-1:0]            dbg_rd
);

  logic [XLEN-1:0] regs_q [REG_NUM];
  logic [XLEN-1:0] regs_d [REG_NUM];

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != '0))
      regs_d[wa] = wd;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd0    = (ra0 == '0)    ? '0 : regs_q[ra0];
    rd1    = (ra1 == '0)    ? '0 : regs_q[ra1];
    dbg_rd = (dbg_ra == '0) ? '0 : regs_q[dbg_ra];
`ifdef RF_BYPASS_EN
    if (we && (wa != '0) && (wa == ra0)) rd0 = wd;
    if (we && (wa != '0) && (wa == ra1)) rd1 = wd;
`endif
  end

  reg_scoreboard #(.REG_NUM(REG_NUM)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .ld_issue (ld_issue),
    .ld_rd    (ld_rd),
    .flush    (flush),
    .ra0      (ra0),
    .ra1      (ra1),
    .hazard   (hazard)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected outputs per cycle, a monitor compares them.
// Expectations follow RF_BYPASS_EN when it is defined for the build.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, we, ld_issue, flush, hazard;
  logic [4:0]  ra0, ra1, wa, ld_rd, dbg_ra;
  logic [31:0] rd0, rd1, wd, dbg_rd;

  typedef enum int {S_RD0, S_RD1, S_DBG, S_HAZ} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .we(we), .wa(wa), .wd(wd), .ld_issue(ld_issue), .ld_rd(ld_rd),
    .flush(flush), .hazard(hazard), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
  );

  task automatic expect_out(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  // Advance to just after the next edge, then drive a full input vector.
  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic li, input logic [4:0] lr, input logic fl,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dr);
    @(posedge clk); #1;
    rst = r; we = w; wa = a; wd = d; ld_issue = li; ld_rd = lr; flush = fl;
    ra0 = r0; ra1 = r1; dbg_ra = dr;
  endtask

  // Monitor: outputs are combinational, so every queued check is due at this cycle's negedge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.sig)
          S_RD0:   act = rd0;
          S_RD1:   act = rd1;
          S_DBG:   act = dbg_rd;
          default: act = {31'd0, hazard};
        endcase
        n_run++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ld_issue = 1'b0; ld_rd = '0;
    flush = 1'b0; ra0 = '0; ra1 = '0; dbg_ra = '0;

    // Reset beats a write and a load in the same cycle.
    step(1, 1, 5, 32'hDEAD_BEEF, 1, 5, 0, 0, 0, 5);
    step(0, 0, 0, 0, 0, 0, 0, 5, 0, 5);
    expect_out(S_DBG, 32'h0, "rst_dbg5");
    expect_out(S_RD0, 32'h0, "rst_rd0_5");
    expect_out(S_HAZ, 32'h0, "rst_hazard");

    // Write to x0 is discarded.
    step(0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    expect_out(S_RD0, 32'h0, "x0_wr_rd0");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(S_RD0, 32'h0, "x0_rd0");
    expect_out(S_DBG, 32'h0, "x0_dbg");

    // x7 write with same-cycle read on port 1.
    step(0, 1, 7, 32'h1111_0000, 0, 0, 0, 0, 7, 7);
    expect_out(S_RD1, BYP ? 32'h1111_0000 : 32'h0, "x7_first_rd1");
    expect_out(S_DBG, 32'h0, "x7_first_dbg_nobypass");
    step(0, 1, 7, 32'hA5A5_0001, 0, 0, 0, 0, 7, 7);
    expect_out(S_RD1, BYP ? 32'hA5A5_0001 : 32'h1111_0000, "x7_same_cycle_rd1");
    expect_out(S_DBG, 32'h1111_0000, "x7_dbg_committed");
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    expect_out(S_RD1, 32'hA5A5_0001, "x7_next_rd1");
    expect_out(S_DBG, 32'hA5A5_0001, "x7_next_dbg");

    // Load to x3, then its write-back.
    step(0, 0, 0, 0, 1, 3, 0, 3, 0, 0);
    expect_out(S_HAZ, 32'h0, "ld3_issue_cycle_haz");
    step(0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    expect_out(S_HAZ, 32'h1, "ld3_busy_haz");
    step(0, 1, 3, 32'h42, 0, 0, 0, 3, 0, 0);
    expect_out(S_HAZ, BYP ? 32'h0 : 32'h1, "ld3_wb_haz");
    expect_out(S_RD0, BYP ? 32'h42 : 32'h0, "ld3_wb_rd0");
    step(0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    expect_out(S_HAZ, 32'h0, "ld3_after_haz");
    expect_out(S_RD0, 32'h42, "ld3_after_rd0");

    // Set and clear of x9 in one cycle: set wins, data still written.
    step(0, 1, 9, 32'h9999_0009, 1, 9, 0, 9, 0, 9);
    expect_out(S_HAZ, 32'h0, "x9_setclr_cycle_haz");
    step(0, 0, 0, 0, 0, 0, 0, 9, 0, 9);
    expect_out(S_HAZ, 32'h1, "x9_set_wins_haz");
    expect_out(S_RD0, 32'h9999_0009, "x9_rd0");
    expect_out(S_DBG, 32'h9999_0009, "x9_dbg");

    // Different indices: set x4, clear x9 together; then set x6.
    step(0, 1, 9, 32'h5, 1, 4, 0, 9, 0, 0);
    expect_out(S_HAZ, BYP ? 32'h0 : 32'h1, "x9_clear_cycle_haz");
    step(0, 0, 0, 0, 1, 6, 0, 9, 0, 0);
    expect_out(S_HAZ, 32'h0, "x9_cleared_haz");
    step(0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
    expect_out(S_HAZ, 32'h1, "x4_busy_haz");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    expect_out(S_HAZ, 32'h1, "x6_busy_port1_haz");

    // Flush clears all busy and drops a same-cycle load to x8.
    step(0, 0, 0, 0, 1, 8, 1, 4, 0, 0);
    expect_out(S_HAZ, 32'h1, "pre_flush_haz");
    step(0, 0, 0, 0, 0, 0, 0, 4, 8, 0);
    expect_out(S_HAZ, 32'h0, "flush_x4_x8_haz");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    expect_out(S_HAZ, 32'h0, "flush_x6_haz");

    // Load to x0 never marks busy.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(S_HAZ, 32'h0, "ld_x0_haz");

    // Reset mid-operation discards a pending load and a concurrent write.
    step(0, 0, 0, 0, 1, 12, 0, 0, 0, 0);
    step(1, 1, 7, 32'hFFFF_FFFF, 1, 13, 0, 12, 0, 0);
    expect_out(S_HAZ, 32'h1, "pre_rst_x12_haz");
    step(0, 0, 0, 0, 0, 0, 0, 12, 7, 7);
    expect_out(S_HAZ, 32'h0, "post_rst_haz");
    expect_out(S_RD1, 32'h0, "post_rst_rd1");
    expect_out(S_DBG, 32'h0, "post_rst_dbg");

    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      #100000;
    join_any
    repeat (2) @(posedge clk);
    if (!done) begin
      n_run++; n_fail++;
      $display("FAIL timeout: stimulus incomplete");
    end
    if (q.size() != 0) begin
      n_run++; n_fail++;
      $display("FAIL leftover: %0d expectations unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
